// File: rtl/risc_id_ex_pipe_reg_if.sv
// Decode/Execute stage bundle: D-side fields flow in, registered E-side copies flow out.
interface risc_id_ex_pipe_reg_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            valid_d;
  logic            branch_d;
  logic [1:0]      result_src_d;
  logic            mem_write_d;
  logic            alu_src_d;
  logic            reg_write_d;
  logic [2:0]      alu_control_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic [XLEN-1:0] imm_ext_d;
  logic [RA_W-1:0] rs1_d;
  logic [RA_W-1:0] rs2_d;
  logic [RA_W-1:0] rd_d;

  logic            valid_e;
  logic            branch_e;
  logic [1:0]      result_src_e;
  logic            mem_write_e;
  logic            alu_src_e;
  logic            reg_write_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pc_plus4_e;
  logic [XLEN-1:0] imm_ext_e;
  logic [RA_W-1:0] rs1_e;
  logic [RA_W-1:0] rs2_e;
  logic [RA_W-1:0] rd_e;

  modport master (
    output valid_d, branch_d, result_src_d, mem_write_d, alu_src_d, reg_write_d,
           alu_control_d, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d, rs1_d, rs2_d, rd_d,
    input  valid_e, branch_e, result_src_e, mem_write_e, alu_src_e, reg_write_e,
           alu_control_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, rs1_e, rs2_e, rd_e
  );

  modport slave (
    input  valid_d, branch_d, result_src_d, mem_write_d, alu_src_d, reg_write_d,
           alu_control_d, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d, rs1_d, rs2_d, rd_d,
    output valid_e, branch_e, result_src_e, mem_write_e, alu_src_e, reg_write_e,
           alu_control_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, rs1_e, rs2_e, rd_e
  );
endinterface

// File: rtl/risc_id_ex_pipe_reg.sv
// Decode->Execute pipeline register with stall/flush and saturating instruction/bubble counters.
// Priority each edge: rst > flush > stall > load.
module risc_id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_e_i,
  input  logic                 flush_e_i,
  risc_id_ex_pipe_reg_if.slave pipe,
  output logic [CNT_W-1:0]     instr_cnt_o,
  output logic [CNT_W-1:0]     bubble_cnt_o
);

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } ex_fields_t;

  ex_fields_t       e_q, e_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    e_d          = e_q;
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_e_i) begin
      // a bubble carries rd=0 so forwarding logic can never match it
      e_d          = '0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else if (!stall_e_i) begin
      e_d.valid       = pipe.valid_d;
      e_d.branch      = pipe.branch_d & pipe.valid_d;
      e_d.result_src  = pipe.result_src_d;
      e_d.mem_write   = pipe.mem_write_d & pipe.valid_d;
      e_d.alu_src     = pipe.alu_src_d;
      e_d.reg_write   = pipe.reg_write_d & pipe.valid_d;
      e_d.alu_control = pipe.alu_control_d;
      e_d.rd1         = pipe.rd1_d;
      e_d.rd2         = pipe.rd2_d;
      e_d.pc          = pipe.pc_d;
      e_d.pc_plus4    = pipe.pc_plus4_d;
      e_d.imm_ext     = pipe.imm_ext_d;
      e_d.rs1         = pipe.rs1_d;
      e_d.rs2         = pipe.rs2_d;
      e_d.rd          = pipe.rd_d;
      if (pipe.valid_d) instr_cnt_d  = sat_inc(instr_cnt_q);
      else              bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q          <= '0;
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      e_q          <= e_d;
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign pipe.valid_e       = e_q.valid;
  assign pipe.branch_e      = e_q.branch;
  assign pipe.result_src_e  = e_q.result_src;
  assign pipe.mem_write_e   = e_q.mem_write;
  assign pipe.alu_src_e     = e_q.alu_src;
  assign pipe.reg_write_e   = e_q.reg_write;
  assign pipe.alu_control_e = e_q.alu_control;
  assign pipe.rd1_e         = e_q.rd1;
  assign pipe.rd2_e         = e_q.rd2;
  assign pipe.pc_e          = e_q.pc;
  assign pipe.pc_plus4_e    = e_q.pc_plus4;
  assign pipe.imm_ext_e     = e_q.imm_ext;
  assign pipe.rs1_e         = e_q.rs1;
  assign pipe.rs2_e         = e_q.rs2;
  assign pipe.rd_e          = e_q.rd;

  assign instr_cnt_o  = instr_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_risc_id_ex_pipe_reg.sv
// Bench for risc_id_ex_pipe_reg: directed vector table, counter saturation run, random run vs model.
module tb_risc_id_ex_pipe_reg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } dfields_t;

  typedef struct {
    logic     rst, stall, flush;
    dfields_t d;
    logic     x_valid, x_branch, x_reg_write, x_mem_write;
    int       x_rd, x_instr, x_bubble;
  } vec_t;

  logic clk = 1'b0;
  logic rst, stall_e, flush_e;
  dfields_t din;
  logic [15:0] instr_cnt, bubble_cnt;
  logic [1:0]  instr_cnt_s, bubble_cnt_s;

  risc_id_ex_pipe_reg_if #(.XLEN(XLEN), .RA_W(RA_W)) pipe ();
  risc_id_ex_pipe_reg_if #(.XLEN(XLEN), .RA_W(RA_W)) pipe_s ();

  risc_id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .stall_e_i(stall_e), .flush_e_i(flush_e),
    .pipe(pipe.slave), .instr_cnt_o(instr_cnt), .bubble_cnt_o(bubble_cnt));

  risc_id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .stall_e_i(stall_e), .flush_e_i(flush_e),
    .pipe(pipe_s.slave), .instr_cnt_o(instr_cnt_s), .bubble_cnt_o(bubble_cnt_s));

  always #5 clk = ~clk;

  assign pipe.valid_d = din.valid;           assign pipe_s.valid_d = din.valid;
  assign pipe.branch_d = din.branch;         assign pipe_s.branch_d = din.branch;
  assign pipe.result_src_d = din.result_src; assign pipe_s.result_src_d = din.result_src;
  assign pipe.mem_write_d = din.mem_write;   assign pipe_s.mem_write_d = din.mem_write;
  assign pipe.alu_src_d = din.alu_src;       assign pipe_s.alu_src_d = din.alu_src;
  assign pipe.reg_write_d = din.reg_write;   assign pipe_s.reg_write_d = din.reg_write;
  assign pipe.alu_control_d = din.alu_control; assign pipe_s.alu_control_d = din.alu_control;
  assign pipe.rd1_d = din.rd1;               assign pipe_s.rd1_d = din.rd1;
  assign pipe.rd2_d = din.rd2;               assign pipe_s.rd2_d = din.rd2;
  assign pipe.pc_d = din.pc;                 assign pipe_s.pc_d = din.pc;
  assign pipe.pc_plus4_d = din.pc_plus4;     assign pipe_s.pc_plus4_d = din.pc_plus4;
  assign pipe.imm_ext_d = din.imm_ext;       assign pipe_s.imm_ext_d = din.imm_ext;
  assign pipe.rs1_d = din.rs1;               assign pipe_s.rs1_d = din.rs1;
  assign pipe.rs2_d = din.rs2;               assign pipe_s.rs2_d = din.rs2;
  assign pipe.rd_d = din.rd;                 assign pipe_s.rd_d = din.rd;

  int errors = 0;
  int checks = 0;

  // reference model: what E should hold, and how many instructions/bubbles have entered it
  dfields_t exp_e;
  int exp_instr, exp_bubble, exp_instr_s, exp_bubble_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bump(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  task automatic model_edge();
    if (rst) begin
      exp_e = '0;
      exp_instr = 0; exp_bubble = 0; exp_instr_s = 0; exp_bubble_s = 0;
    end else if (flush_e) begin
      exp_e = '0;
      exp_bubble   = bump(exp_bubble, 65535);
      exp_bubble_s = bump(exp_bubble_s, 3);
    end else if (!stall_e) begin
      exp_e = din;
      if (!din.valid) begin
        exp_e.reg_write = 1'b0;
        exp_e.mem_write = 1'b0;
        exp_e.branch    = 1'b0;
        exp_bubble   = bump(exp_bubble, 65535);
        exp_bubble_s = bump(exp_bubble_s, 3);
      end else begin
        exp_instr   = bump(exp_instr, 65535);
        exp_instr_s = bump(exp_instr_s, 3);
      end
    end
  endtask

  task automatic check_all();
    chk("valid_e", 64'(pipe.valid_e), 64'(exp_e.valid));
    chk("branch_e", 64'(pipe.branch_e), 64'(exp_e.branch));
    chk("result_src_e", 64'(pipe.result_src_e), 64'(exp_e.result_src));
    chk("mem_write_e", 64'(pipe.mem_write_e), 64'(exp_e.mem_write));
    chk("alu_src_e", 64'(pipe.alu_src_e), 64'(exp_e.alu_src));
    chk("reg_write_e", 64'(pipe.reg_write_e), 64'(exp_e.reg_write));
    chk("alu_control_e", 64'(pipe.alu_control_e), 64'(exp_e.alu_control));
    chk("rd1_e", 64'(pipe.rd1_e), 64'(exp_e.rd1));
    chk("rd2_e", 64'(pipe.rd2_e), 64'(exp_e.rd2));
    chk("pc_e", 64'(pipe.pc_e), 64'(exp_e.pc));
    chk("pc_plus4_e", 64'(pipe.pc_plus4_e), 64'(exp_e.pc_plus4));
    chk("imm_ext_e", 64'(pipe.imm_ext_e), 64'(exp_e.imm_ext));
    chk("rs1_e", 64'(pipe.rs1_e), 64'(exp_e.rs1));
    chk("rs2_e", 64'(pipe.rs2_e), 64'(exp_e.rs2));
    chk("rd_e", 64'(pipe.rd_e), 64'(exp_e.rd));
    chk("sat_rd_e", 64'(pipe_s.rd_e), 64'(exp_e.rd));
    chk("instr_cnt", 64'(instr_cnt), 64'(exp_instr));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
    chk("sat_instr_cnt", 64'(instr_cnt_s), 64'(exp_instr_s));
    chk("sat_bubble_cnt", 64'(bubble_cnt_s), 64'(exp_bubble_s));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic dfields_t mkd(input logic v, input logic br, input logic [1:0] rs,
                                   input logic mw, input logic as, input logic rw,
                                   input logic [2:0] ac, input logic [4:0] rd,
                                   input logic [31:0] imm);
    dfields_t d;
    d.valid = v; d.branch = br; d.result_src = rs; d.mem_write = mw; d.alu_src = as;
    d.reg_write = rw; d.alu_control = ac; d.rd = rd; d.imm_ext = imm;
    d.rd1 = 32'hA000_0000 | 32'(rd); d.rd2 = 32'hB000_0000 | 32'(rd);
    d.pc = 32'h0000_1000 + 32'(rd) * 4; d.pc_plus4 = d.pc + 32'd4;
    d.rs1 = rd + 5'd1; d.rs2 = rd + 5'd2;
    return d;
  endfunction

  function automatic vec_t mkv(input logic r, input logic s, input logic f, input dfields_t d,
                               input logic xv, input logic xb, input logic xrw, input logic xmw,
                               input int xrd, input int xi, input int xbb);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.d = d;
    v.x_valid = xv; v.x_branch = xb; v.x_reg_write = xrw; v.x_mem_write = xmw;
    v.x_rd = xrd; v.x_instr = xi; v.x_bubble = xbb;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    rst = 1'b0; stall_e = 1'b0; flush_e = 1'b0; din = '0;
    exp_e = '0; exp_instr = 0; exp_bubble = 0; exp_instr_s = 0; exp_bubble_s = 0;

    //              rst  stl  fls  inputs                                                      v  br rw mw rd ins bub
    vecs[0]  = mkv(1'b1,1'b0,1'b0, mkd(1,1,2'b01,1,1,1,3'd2, 5'd7, 32'h44),                  0,0,0,0, 0, 0,0);
    vecs[1]  = mkv(1'b1,1'b0,1'b0, mkd(1,1,2'b10,1,0,1,3'd5, 5'd9, 32'h55),                  0,0,0,0, 0, 0,0);
    vecs[2]  = mkv(1'b0,1'b0,1'b0, mkd(1,1,2'b01,0,1,1,3'd0, 5'd5, 32'h10),                  1,1,1,0, 5, 1,0);
    vecs[3]  = mkv(1'b0,1'b1,1'b0, mkd(1,0,2'b00,1,0,0,3'd3, 5'd9, 32'h20),                  1,1,1,0, 5, 1,0);
    vecs[4]  = mkv(1'b0,1'b1,1'b0, mkd(0,1,2'b10,0,1,1,3'd4, 5'd10,32'h30),                  1,1,1,0, 5, 1,0);
    vecs[5]  = mkv(1'b0,1'b1,1'b0, mkd(1,0,2'b01,1,1,0,3'd6, 5'd11,32'h40),                  1,1,1,0, 5, 1,0);
    vecs[6]  = mkv(1'b0,1'b0,1'b0, mkd(1,0,2'b00,0,0,1,3'd1, 5'd12,32'h50),                  1,0,1,0,12, 2,0);
    vecs[7]  = mkv(1'b0,1'b1,1'b1, mkd(1,0,2'b00,1,1,0,3'd0, 5'd3, 32'h8),                   0,0,0,0, 0, 2,1);
    vecs[8]  = mkv(1'b0,1'b0,1'b0, mkd(0,1,2'b01,1,1,1,3'd2, 5'd14,32'h60),                  0,0,0,0,14, 2,2);
    vecs[9]  = mkv(1'b0,1'b0,1'b1, mkd(1,1,2'b01,1,1,1,3'd7, 5'd20,32'h70),                  0,0,0,0, 0, 2,3);
    vecs[10] = mkv(1'b0,1'b0,1'b0, mkd(1,1,2'b00,1,1,0,3'd0, 5'd31,32'h80),                  1,1,0,1,31, 3,3);

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; stall_e = vecs[i].stall; flush_e = vecs[i].flush; din = vecs[i].d;
      cycle();
      chk($sformatf("tbl%0d_valid", i), 64'(pipe.valid_e), 64'(vecs[i].x_valid));
      chk($sformatf("tbl%0d_branch", i), 64'(pipe.branch_e), 64'(vecs[i].x_branch));
      chk($sformatf("tbl%0d_reg_write", i), 64'(pipe.reg_write_e), 64'(vecs[i].x_reg_write));
      chk($sformatf("tbl%0d_mem_write", i), 64'(pipe.mem_write_e), 64'(vecs[i].x_mem_write));
      chk($sformatf("tbl%0d_rd", i), 64'(pipe.rd_e), 64'(vecs[i].x_rd));
      chk($sformatf("tbl%0d_instr", i), 64'(instr_cnt), 64'(vecs[i].x_instr));
      chk($sformatf("tbl%0d_bubble", i), 64'(bubble_cnt), 64'(vecs[i].x_bubble));
    end

    // 2-bit counter: five loads saturate at 3, then reset mid-run clears it
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      din = mkd(1,0,2'b00,0,0,1,3'd0, 5'(k), 32'(k));
      cycle();
      chk($sformatf("sat_load%0d", k), 64'(instr_cnt_s), 64'((k < 3) ? k : 3));
    end
    chk("sat_wide_instr", 64'(instr_cnt), 64'd5);
    rst = 1'b1;
    cycle();
    chk("sat_after_rst", 64'(instr_cnt_s), 64'd0);
    chk("wide_after_rst", 64'(instr_cnt), 64'd0);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 39) == 0);
      flush_e = ($urandom_range(0, 5) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      din.valid       = ($urandom_range(0, 3) != 0);
      din.branch      = 1'($urandom);
      din.result_src  = 2'($urandom);
      din.mem_write   = 1'($urandom);
      din.alu_src     = 1'($urandom);
      din.reg_write   = 1'($urandom);
      din.alu_control = 3'($urandom);
      din.rd1         = $urandom;
      din.rd2         = $urandom;
      din.pc          = $urandom;
      din.pc_plus4    = $urandom;
      din.imm_ext     = $urandom;
      din.rs1         = 5'($urandom);
      din.rs2         = 5'($urandom);
      din.rd          = 5'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
